// File: rtl/uart_imem_loader.sv
// UART-framed program loader for the RV32 instruction memory: A5, N (LE16), N words (LE), XOR checksum.
// Holds the core in reset from the sync byte until a frame with a good checksum has been written.
//   state  | meaning
//   IDLE   | waiting for sync byte 0xA5, other bytes ignored
//   CNT_LO | waiting for word count low byte
//   CNT_HI | waiting for word count high byte, range check
//   DATA   | assembling words, writing each 4th byte
//   CSUM   | waiting for checksum byte
//   DONE   | one-cycle success, releases cpu_hold
//   ERR    | one-cycle failure, back to IDLE
module uart_imem_loader #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned MAX_WORDS    = 256,
  parameter int unsigned TIMEOUT_CLKS = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam int IDX_W  = $clog2(MAX_WORDS + 1);
  localparam logic [BAUD_W-1:0] BIT_RELOAD  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_RELOAD = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMO_W-1:0]  TMO_RELOAD  = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [15:0]       MAX_N       = 16'(MAX_WORDS);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR} state_t;

  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t         rx_state_q, rx_state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_vld_q, byte_vld_d;
  logic              frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= R_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_state_q  <= rx_state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    baud_d      = (baud_q != '0) ? baud_q - BAUD_W'(1) : baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          baud_d     = HALF_RELOAD;
          rx_state_d = R_START;
        end
      end
      R_START: begin
        if (baud_q == '0) begin
          if (rx_sync_q) begin
            rx_state_d = R_IDLE;  // start bit did not hold: glitch
          end else begin
            rx_state_d = R_DATA;
            baud_d     = BIT_RELOAD;
            bit_d      = '0;
          end
        end
      end
      R_DATA: begin
        if (baud_q == '0) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          baud_d  = BIT_RELOAD;
          if (bit_q == 3'd7) rx_state_d = R_STOP;
          else               bit_d      = bit_q + 3'd1;
        end
      end
      default: begin
        if (baud_q == '0) begin
          rx_state_d  = R_IDLE;
          byte_vld_d  = rx_sync_q;
          frame_err_d = !rx_sync_q;
        end
      end
    endcase
  end

  state_t           state_q, state_d;
  logic [7:0]       cnt_lo_q, cnt_lo_d;
  logic [15:0]      n_q, n_d, n_rx;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [31:0]      asm_q, asm_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]       csum_q, csum_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic             fail;

  assign n_rx       = {shift_q, cnt_lo_q};
  assign busy       = (state_q == CNT_LO) || (state_q == CNT_HI) || (state_q == DATA) || (state_q == CSUM);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign err        = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_lo_q <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      asm_q    <= '0;
      csum_q   <= '0;
      tmo_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_lo_q <= cnt_lo_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      asm_q    <= asm_d;
      csum_q   <= csum_d;
      tmo_q    <= tmo_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_lo_d = cnt_lo_q;
    n_d      = n_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    asm_d    = asm_q;
    csum_d   = csum_q;
    tmo_d    = byte_vld_q ? TMO_RELOAD : ((tmo_q != '0) ? tmo_q - TMO_W'(1) : tmo_q);
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    hold_d   = hold_q;
    done_d   = 1'b0;
    err_d    = err_q;
    fail     = 1'b0;
    case (state_q)
      IDLE: begin
        if (byte_vld_q && shift_q == 8'hA5) begin
          state_d = CNT_LO;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          idx_d   = '0;
          bcnt_d  = '0;
          csum_d  = '0;
        end
      end
      CNT_LO: begin
        if (byte_vld_q) begin
          cnt_lo_d = shift_q;
          state_d  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (byte_vld_q) begin
          n_d = n_rx;
          if (n_rx > MAX_N)       fail    = 1'b1;
          else if (n_rx == 16'd0) state_d = CSUM;
          else                    state_d = DATA;
        end
      end
      DATA: begin
        if (byte_vld_q) begin
          asm_d  = {shift_q, asm_q[31:8]};
          csum_d = csum_q ^ shift_q;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = 32'({idx_q, 2'b00});
            wdata_d = {shift_q, asm_q[31:8]};
            idx_d   = idx_q + IDX_W'(1);
            if (16'(idx_q) == n_q - 16'd1) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (byte_vld_q) begin
          if (shift_q == csum_q) state_d = DONE;
          else                   fail    = 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        hold_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
    // Framing errors and inter-byte timeouts only matter while a frame is open.
    if (busy && (frame_err_q || (!byte_vld_q && tmo_q == '0))) fail = 1'b1;
    if (fail) begin
      state_d = ERR;
      err_d   = 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_imem_loader.sv
// Randomized frame bench: expected memory writes and done pulses go into queues, a monitor pops them.
module tb_uart_imem_loader;
  localparam int CPB   = 10;
  localparam int MAX_W = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        imem_we, cpu_hold, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  int          exp_done[$];
  logic [31:0] words[$];
  int          checks = 0;
  int          failures = 0;

  uart_imem_loader #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .MAX_WORDS(MAX_W), .TIMEOUT_CLKS(500)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (imem_we) begin
        if (exp_wr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual addr=%h data=%h required=no write", imem_addr, imem_wdata);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("write_addr", imem_addr, e.addr);
          chk("write_data", imem_wdata, e.data);
        end
      end
      if (done) begin
        checks++;
        if (exp_done.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          void'(exp_done.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Reference: frame bytes, checksum and expected writes derived from the global words queue.
  task automatic send_frame(input int n, input bit use_ovr, input logic [7:0] ovr);
    logic [7:0]  cs;
    logic [15:0] n16;
    logic [31:0] w;
    cs  = 8'h00;
    n16 = 16'(n);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    end
    if (n <= MAX_W)
      for (int i = 0; i < n; i++) exp_wr.push_back('{addr: 32'(i * 4), data: words[i]});
    if (n <= MAX_W && (!use_ovr || ovr == cs)) exp_done.push_back(n);
    send_byte(8'hA5);
    send_byte(n16[7:0]);
    send_byte(n16[15:8]);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    end
    send_byte(use_ovr ? ovr : cs);
  endtask

  task automatic settle(input string tag, input logic exp_hold, input logic exp_err);
    repeat (10) @(negedge clk);
    chk({tag, "_writes_pending"}, 32'(exp_wr.size()), 32'd0);
    chk({tag, "_done_pending"}, 32'(exp_done.size()), 32'd0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, exp_hold});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_flags"}, {28'd0, cpu_hold, busy, done, err}, 32'd0);
  endtask

  initial begin
    int n;
    bit bad;
    rx    = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Two-word program with the correct XOR checksum.
    words = {32'h0050_0013, 32'h0010_0093};
    send_frame(2, 1'b0, 8'h00);
    settle("good2", 1'b0, 1'b0);

    // Same program, wrong checksum, then recovery with a good frame.
    send_frame(2, 1'b1, 8'h00);
    settle("badcs", 1'b1, 1'b1);
    send_frame(2, 1'b0, 8'h00);
    settle("recover", 1'b0, 1'b0);

    // Word count 257 exceeds the memory depth.
    send_byte(8'hA5);
    send_byte(8'h01);
    chk("n257_err_before", {31'd0, err}, 32'd0);
    send_byte(8'h01);
    settle("n257", 1'b1, 1'b1);

    // Boundary: empty program, then a non-sync byte while idle.
    words = {};
    send_frame(0, 1'b0, 8'h00);
    settle("n0", 1'b0, 1'b0);
    send_byte(8'h5A);
    settle("idle5a", 1'b0, 1'b0);

    // Inter-byte timeout mid-data.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
    repeat (400) @(negedge clk);
    chk("tmo_not_yet_err", {31'd0, err}, 32'd0);
    chk("tmo_not_yet_busy", {31'd0, busy}, 32'd1);
    repeat (120) @(negedge clk);
    settle("timeout", 1'b1, 1'b1);

    // Framing error (stop bit 0) mid-frame; sync first clears err.
    send_byte(8'hA5);
    chk("sync_clears_err", {31'd0, err}, 32'd0);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h37, 1'b0);
    settle("framing", 1'b1, 1'b1);

    // Random programs, some with a corrupted checksum.
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 5);
      bad = ($urandom_range(0, 3) == 0);
      words = {};
      for (int i = 0; i < n; i++) words.push_back($urandom);
      send_frame(n, bad, bad ? 8'($urandom_range(0, 255)) ^ 8'h00 : 8'h00);
      // A random override may coincide with the true checksum; the model already accounts for that.
      repeat (10) @(negedge clk);
      chk("rand_writes_pending", 32'(exp_wr.size()), 32'd0);
      chk("rand_done_pending", 32'(exp_done.size()), 32'd0);
      chk("rand_hold_eq_err", {31'd0, cpu_hold}, {31'd0, err});
      chk("rand_busy", {31'd0, busy}, 32'd0);
    end

    // Asynchronous reset during the third data byte.
    send_frame(0, 1'b0, 8'h00);
    settle("pre_reset", 1'b0, 1'b0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE);
    rx = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_hold", {31'd0, cpu_hold}, 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (3) @(negedge clk);
    rx = 1'b1;
    reset = 1'b1;
    repeat (150) @(negedge clk);
    words = {32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_006F};
    send_frame(3, 1'b0, 8'h00);
    settle("after_reset", 1'b0, 1'b0);

    // A 2-clock glitch while awaiting the checksum of an empty frame must not become a byte.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (150) @(negedge clk);
    chk("glitch_busy", {31'd0, busy}, 32'd1);
    chk("glitch_err", {31'd0, err}, 32'd0);
    exp_done.push_back(0);
    send_byte(8'h00);
    settle("glitch", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
